// File: rtl/la_iopwrseq.sv
// la_iopwrseq: io-ring power sequencer for one pad-ring side.
// Staggers the enables of N switched supply/ground segments on the way up
// and on the way down, so the ring does not see one large inrush or
// ground-bounce event.
// Optional closed-loop supply-good checking: define LA_IOPWRSEQ_CHECK_EN.
//
// Control protocol (level based, no pulses): the power manager holds en=1
// to request a powered ring and en=0 to request it off. ready=1 means every
// segment is enabled and the ramp is finished. busy=1 means a ramp (up or
// down) is in progress. ready=0 and busy=0 together mean fully off, or
// FAULT when fault=1. en may change at any time; a change that arrives
// mid-ramp reverses the ramp on the edge that samples it.
module la_iopwrseq #(
  parameter int N    = 4,
  parameter int CW   = 8,
  parameter     PROP = "DEFAULT",
  parameter     SIDE = "NO"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic [CW-1:0] delay,
  input  logic [N-1:0]  pwr_ok,
  output logic [N-1:0]  pwr_en,
  output logic          ready,
  output logic          busy,
  output logic          fault
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  // Cell property and ring side are carried for the library flow only.
  localparam int unused_prop_w = $bits(PROP);
  localparam int unused_side_w = $bits(SIDE);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RAMPUP = 3'd1,
    S_ON     = 3'd2,
    S_RAMPDN = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  // state is left as a named enum so checkers can bind to it directly.
  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  pwr_en_nxt;
  logic          ready_nxt, busy_nxt, fault_nxt;
  logic          seg_ok;
  logic          all_ok;

`ifdef LA_IOPWRSEQ_CHECK_EN
  logic [N-1:0] ok_meta, ok_sync;

  // Two-flop synchroniser for the asynchronous supply-good feedback.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ok_meta <= '0;
      ok_sync <= '0;
    end else begin
      ok_meta <= pwr_ok;
      ok_sync <= ok_meta;
    end
  end

  assign seg_ok = ok_sync[idx];
  assign all_ok = &ok_sync;
`else
  // Open loop: the feedback is ignored and FAULT can never be entered.
  logic unused_ok;
  assign unused_ok = ^pwr_ok;
  assign seg_ok    = 1'b1;
  assign all_ok    = 1'b1;
`endif

  // State, pointer, stagger counter and all outputs are registered together.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= S_OFF;
      idx    <= '0;
      cnt    <= '0;
      pwr_en <= '0;
      ready  <= 1'b0;
      busy   <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      pwr_en <= pwr_en_nxt;
      ready  <= ready_nxt;
      busy   <= busy_nxt;
      fault  <= fault_nxt;
    end
  end

  // Next-state logic: a reversal of en always wins over a ramp step.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    pwr_en_nxt = pwr_en;
    case (state)
      S_OFF: begin
        if (en) begin
          state_nxt  = S_RAMPUP;
          idx_nxt    = '0;
          cnt_nxt    = delay;
          pwr_en_nxt = N'(1);
        end
      end
      S_RAMPUP: begin
        if (!en) begin
          state_nxt = S_RAMPDN;
          cnt_nxt   = delay;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (!seg_ok) begin
          state_nxt  = S_FAULT;
          pwr_en_nxt = '0;
        end else if (idx != IDX_LAST) begin
          idx_nxt               = idx + IW'(1);
          pwr_en_nxt[idx + IW'(1)] = 1'b1;
          cnt_nxt               = delay;
        end else begin
          state_nxt = S_ON;
        end
      end
      S_ON: begin
        if (!all_ok) begin
          state_nxt  = S_FAULT;
          pwr_en_nxt = '0;
        end else if (!en) begin
          state_nxt = S_RAMPDN;
          idx_nxt   = IDX_LAST;
          cnt_nxt   = delay;
        end
      end
      S_RAMPDN: begin
        if (en) begin
          // The segment at idx is still on; wait a full stagger before the next one.
          state_nxt = S_RAMPUP;
          cnt_nxt   = delay;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          pwr_en_nxt[idx] = 1'b0;
          if (idx != '0) begin
            idx_nxt = idx - IW'(1);
            cnt_nxt = delay;
          end else begin
            state_nxt = S_OFF;
          end
        end
      end
      S_FAULT: begin
        pwr_en_nxt = '0;
        if (!en) state_nxt = S_OFF;
      end
      default: begin
        state_nxt  = S_OFF;
        idx_nxt    = '0;
        cnt_nxt    = '0;
        pwr_en_nxt = '0;
      end
    endcase
  end

  // Output decode from the next state, so the status flops line up with state.
  always_comb begin
    busy_nxt  = (state_nxt == S_RAMPUP) || (state_nxt == S_RAMPDN);
    ready_nxt = (state_nxt == S_ON);
    fault_nxt = (state_nxt == S_FAULT);
  end

endmodule

// File: tb/tb_la_iopwrseq.sv
// tb_la_iopwrseq: directed and randomized bench for la_iopwrseq (N=4).
// The reference model tracks ramp phases in closed form: a phase starts at
// a known edge with k segments on and the segment count then moves one step
// every delay+1 edges.
module tb_la_iopwrseq;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int W  = N + 3;

  logic          clk = 1'b0;
  logic          nreset;
  logic          en;
  logic [CW-1:0] delay;
  logic [N-1:0]  pwr_ok;
  logic [N-1:0]  pwr_en;
  logic          ready;
  logic          busy;
  logic          fault;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  bit           en_q[$];
  logic [N-1:0] ok_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  la_iopwrseq #(.N(N), .CW(CW), .PROP("DEFAULT"), .SIDE("NO")) dut (
    .clk    (clk),
    .nreset (nreset),
    .en     (en),
    .delay  (delay),
    .pwr_ok (pwr_ok),
    .pwr_en (pwr_en),
    .ready  (ready),
    .busy   (busy),
    .fault  (fault)
  );

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Enables must always be a thermometer code.
  always @(negedge clk) begin
    if (nreset === 1'b1) begin
      checks++;
      assert ((pwr_en & (pwr_en + N'(1))) === '0)
      else begin
        failures++;
        $error("FAIL thermometer observed=%b required=thermometer", pwr_en);
      end
    end
  end

  function automatic logic [W-1:0] pack(bit f, bit r, bit b, int c);
    logic [N-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) if (i < c) t[i] = 1'b1;
    return {f, r, b, t};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] expv);
    logic [W-1:0] obs;
    obs = {fault, ready, busy, pwr_en};
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed={f,r,b,en}=%b required=%b", tag, obs, expv);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Build one random en stream and its expected output per edge.
  task automatic build_trial(input int d, input int body);
    int  dir, r, k0, cprev, c, tail;
    bit  cur, ev, rdy, bsy;
    en_q.delete(); exp_q.delete(); ok_q.delete();
    tail  = (N + 1) * (d + 1) + 2;
    dir   = 0; r = 0; k0 = 0; cprev = 0; cur = 1'b1;
    for (int e = 1; e <= body + tail; e++) begin
      if (e > 1 && $urandom_range(0, 7) == 0) cur = !cur;
      ev = (e > body) ? 1'b0 : cur;
      if (dir == 1 && !ev) begin
        dir = 0; r = e; k0 = cprev;
      end else if (dir == 0 && ev) begin
        dir = 1; r = e; k0 = (cprev == 0) ? 1 : cprev;
      end
      if (dir == 1) begin
        c = k0 + (e - r) / (d + 1);
        if (c > N) c = N;
        rdy = (e >= r + (N - k0 + 1) * (d + 1));
        bsy = !rdy;
      end else begin
        c = k0 - (e - r) / (d + 1);
        if (c < 0) c = 0;
        rdy = 1'b0;
        bsy = (c > 0);
      end
      cprev = c;
      en_q.push_back(ev);
`ifdef LA_IOPWRSEQ_CHECK_EN
      ok_q.push_back('1);
`else
      ok_q.push_back(N'($urandom_range(0, (1 << N) - 1)));
`endif
      exp_q.push_back(pack(1'b0, rdy, bsy, c));
    end
  endtask

  // Scoreboard: play the stream and pop one expectation per edge.
  task automatic run_trial(input int d);
    logic [W-1:0] expv;
    delay = CW'(d);
    while (en_q.size() > 0) begin
      en     = en_q.pop_front();
      pwr_ok = ok_q.pop_front();
      tick();
      expv = exp_q.pop_front();
      check("random", expv);
    end
    pwr_ok = '1;
  endtask

  initial begin
    nreset = 1'b0; en = 1'b1; delay = CW'(3); pwr_ok = '1;

    // Reset with en high: everything stays off.
    tick_n(3);
    check("reset_hold", pack(0, 0, 0, 0));

    // Ramp up, delay=3: bits at edges 1,5,9,13; ready at 17.
    nreset = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      check($sformatf("rampup_e%0d", e),
            pack(0, e >= 17, e <= 16, (e >= 13) ? 4 : (e - 1) / 4 + 1));
    end

    // Ramp down from ON, delay=2.
    delay = CW'(2); en = 1'b0;
    tick_n(3);  check("dn_hold",  pack(0, 0, 1, 4));
    tick();     check("dn_0111",  pack(0, 0, 1, 3));
    tick_n(3);  check("dn_0011",  pack(0, 0, 1, 2));
    tick_n(3);  check("dn_0001",  pack(0, 0, 1, 1));
    tick_n(2);  check("dn_pre0",  pack(0, 0, 1, 1));
    tick();     check("dn_off",   pack(0, 0, 0, 0));

    // Reversal during ramp-up, delay=5, at 0011.
    delay = CW'(5); en = 1'b1;
    tick();     check("rv_e1",    pack(0, 0, 1, 1));
    tick_n(6);  check("rv_e7",    pack(0, 0, 1, 2));
    en = 1'b0;
    tick();     check("rv_e8",    pack(0, 0, 1, 2));
    tick_n(5);  check("rv_e13",   pack(0, 0, 1, 2));
    tick();     check("rv_e14",   pack(0, 0, 1, 1));
    tick_n(5);  check("rv_e19",   pack(0, 0, 1, 1));
    tick();     check("rv_e20",   pack(0, 0, 0, 0));

    // Re-assert en at 0001 during ramp-down: bit 0 must not glitch.
    en = 1'b1;
    tick();     tick_n(6);  check("re_up",  pack(0, 0, 1, 2));
    en = 1'b0;
    tick();     tick_n(6);  check("re_dn",  pack(0, 0, 1, 1));
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();   check($sformatf("re_hold%0d", i), pack(0, 0, 1, 1));
    end
    tick();     check("re_next",  pack(0, 0, 1, 2));
    en = 1'b0;
    tick_n(13); check("re_off",   pack(0, 0, 0, 0));

    // delay=0: one bit per edge, ready on edge 5.
    delay = CW'(0); en = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();   check($sformatf("d0_e%0d", e), pack(0, e == 5, e < 5, (e > 4) ? 4 : e));
    end
    en = 1'b0;
    tick_n(5);  check("d0_off",   pack(0, 0, 0, 0));

    // Async reset mid-ramp at 0111 clears outputs without a clock edge.
    delay = CW'(3); en = 1'b1;
    tick_n(9);  check("ar_0111",  pack(0, 0, 1, 3));
    #3 nreset = 1'b0;
    #1 check("ar_async", pack(0, 0, 0, 0));
    tick();
    nreset = 1'b1;
    tick();     check("ar_restart", pack(0, 0, 1, 1));
    en = 1'b0;
    tick_n(5);  check("ar_off",   pack(0, 0, 0, 0));

    // Randomized streams against the phase model.
    for (int t = 0; t < 8; t++) begin
      int d;
      d = $urandom_range(0, 4);
      build_trial(d, $urandom_range(20, 50));
      run_trial(d);
    end

`ifdef LA_IOPWRSEQ_CHECK_EN
    // Segment 2 never reports good: fault at the step that needs it.
    pwr_ok = 4'b1011; delay = CW'(3); en = 1'b0;
    tick_n(3);
    en = 1'b1;
    tick_n(9);  check("ft_0111",  pack(0, 0, 1, 3));
    tick_n(3);  check("ft_wait",  pack(0, 0, 1, 3));
    tick();     check("ft_entry", pack(1, 0, 0, 0));
    tick_n(3);  check("ft_hold",  pack(1, 0, 0, 0));
    en = 1'b0;
    tick();     check("ft_clear", pack(0, 0, 0, 0));
    pwr_ok = '1;
`else
    // Open loop: a bad supply-good pattern changes nothing.
    pwr_ok = 4'b1011; delay = CW'(0); en = 1'b1;
    tick_n(5);  check("ol_ready", pack(0, 1, 0, 4));
    en = 1'b0;
    tick_n(5);  check("ol_off",   pack(0, 0, 0, 0));
    pwr_ok = '1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
